// File: rtl/pd_pkg.sv
// Shared constants and types for the pool-device packet serializer and deframer.
// Holds the sync byte, payload length, status word encodings, the packed hash array type and
// the deframer state enumeration.
package pd_pkg;

  localparam logic [7:0]  PD_SYNC_BYTE    = 8'h54;
  localparam int unsigned PD_HASH_WORDS   = 18;
  localparam logic [15:0] PD_STATUS_EMPTY = 16'd1;
  localparam logic [15:0] PD_STATUS_BUSY  = 16'd0;

  typedef logic [PD_HASH_WORDS-1:0][15:0] pd_hash_t;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    STATUS  = 2'd1,
    PAYLOAD = 2'd2,
    FULL    = 2'd3
  } pd_deframe_state_t;

  // A status word is well formed only if it is one of the two defined encodings.
  function automatic logic pd_status_ok(input logic [15:0] word);
    return (word == PD_STATUS_EMPTY) || (word == PD_STATUS_BUSY);
  endfunction

endpackage

// File: rtl/pd_err_sat_counter.sv
// 8-bit saturating event counter.
// Ports:
//   clk   - clock
//   n_rst - asynchronous active-low reset, clears the count
//   inc   - add one this cycle (held at 8'hFF once reached)
//   count - current count
module pd_err_sat_counter (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       inc,
  output logic [7:0] count
);

  logic [7:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= 8'h00;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pd_packet_deframer.sv
// Receive-side packet deframer for the pool-device serial link.
// Hunts the 16-bit word stream for a {SYNC_BYTE, PID} header, then takes one status word and
// HASH_WORDS payload words and holds the assembled packet under a valid/ack handshake.
// Optional build macro: PD_PID_FILTER_EN adds expected_pid; only headers carrying that PID
// are accepted, others count as sync errors.
// Ports:
//   clk, n_rst          - clock, asynchronous active-low reset
//   rx_data/rx_valid    - input stream; rx_ready low only while a packet is held
//   clear               - synchronous abort back to hunting, drops any partial packet
//   pkt_ack             - consumer has taken the held packet
//   pkt_valid           - packet held on pkt_pid / pkt_tx_empty / pkt_hash
//   sync_err, fmt_err   - one-cycle error pulses (bad header, bad status word)
//   err_cnt             - saturating count of error pulses
module pd_packet_deframer
  import pd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE  = PD_SYNC_BYTE,
  parameter int unsigned HASH_WORDS = PD_HASH_WORDS
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic [15:0]                 rx_data,
  input  logic                        rx_valid,
  output logic                        rx_ready,
  input  logic                        clear,
  input  logic                        pkt_ack,
`ifdef PD_PID_FILTER_EN
  input  logic [7:0]                  expected_pid,
`endif
  output logic                        pkt_valid,
  output logic [7:0]                  pkt_pid,
  output logic                        pkt_tx_empty,
  output logic [HASH_WORDS-1:0][15:0] pkt_hash,
  output logic                        sync_err,
  output logic                        fmt_err,
  output logic [7:0]                  err_cnt
);

  localparam logic [4:0] LastIdx = 5'(HASH_WORDS - 1);

  pd_deframe_state_t           state_d, state_q;
  logic [4:0]                  cnt_d, cnt_q;
  logic [7:0]                  pid_d, pid_q;
  logic                        tx_empty_d, tx_empty_q;
  logic [HASH_WORDS-1:0][15:0] hash_d, hash_q;
  logic                        sync_err_d, sync_err_q;
  logic                        fmt_err_d, fmt_err_q;
  logic                        accept;
  logic                        header_ok;

  assign rx_ready = (state_q != FULL);
  assign accept   = rx_valid && rx_ready;

`ifdef PD_PID_FILTER_EN
  assign header_ok = (rx_data[15:8] == SYNC_BYTE) && (rx_data[7:0] == expected_pid);
`else
  assign header_ok = (rx_data[15:8] == SYNC_BYTE);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pid_d      = pid_q;
    tx_empty_d = tx_empty_q;
    hash_d     = hash_q;
    sync_err_d = 1'b0;
    fmt_err_d  = 1'b0;

    // clear wins over everything, including a word transferring this cycle.
    if (clear) begin
      state_d = HUNT;
      cnt_d   = 5'd0;
    end else begin
      unique case (state_q)
        HUNT: begin
          if (accept) begin
            if (header_ok) begin
              pid_d   = rx_data[7:0];
              state_d = STATUS;
            end else begin
              sync_err_d = 1'b1;
            end
          end
        end
        STATUS: begin
          if (accept) begin
            if (pd_status_ok(rx_data)) begin
              tx_empty_d = rx_data[0];
              cnt_d      = 5'd0;
              state_d    = PAYLOAD;
            end else begin
              // The rejected word is dropped, not re-examined as a header.
              fmt_err_d = 1'b1;
              state_d   = HUNT;
            end
          end
        end
        PAYLOAD: begin
          if (accept) begin
            // First payload word lands in the highest index.
            hash_d[LastIdx - cnt_q] = rx_data;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == LastIdx) begin
              state_d = FULL;
            end
          end
        end
        FULL: begin
          if (pkt_ack) begin
            state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= HUNT;
      cnt_q      <= 5'd0;
      pid_q      <= 8'h00;
      tx_empty_q <= 1'b0;
      hash_q     <= '0;
      sync_err_q <= 1'b0;
      fmt_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pid_q      <= pid_d;
      tx_empty_q <= tx_empty_d;
      hash_q     <= hash_d;
      sync_err_q <= sync_err_d;
      fmt_err_q  <= fmt_err_d;
    end
  end

  // Fed from the next-state pulses so the count moves in the same cycle the pulse appears.
  pd_err_sat_counter u_err_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (sync_err_d | fmt_err_d),
    .count (err_cnt)
  );

  assign pkt_valid    = (state_q == FULL);
  assign pkt_pid      = pid_q;
  assign pkt_tx_empty = tx_empty_q;
  assign pkt_hash     = hash_q;
  assign sync_err     = sync_err_q;
  assign fmt_err      = fmt_err_q;

endmodule

// File: tb/tb_pd_packet_deframer.sv
// Scoreboard bench for pd_packet_deframer: the driver pushes the expected outcome of each
// stream segment (sync error, format error or complete packet) into a queue, and an
// independent monitor pops and compares whenever the DUT pulses an error or presents a packet.
module tb_pd_packet_deframer;
  import pd_pkg::*;

  localparam int unsigned HW = PD_HASH_WORDS;
  localparam int EvSync = 0;
  localparam int EvFmt  = 1;
  localparam int EvPkt  = 2;

  typedef struct {
    int         kind;
    logic [7:0] pid;
    logic       te;
    pd_hash_t   hash;
  } exp_t;

  logic           clk = 1'b0;
  logic           n_rst = 1'b0;
  logic [15:0]    rx_data;
  logic           rx_valid;
  logic           rx_ready;
  logic           clear;
  logic           pkt_ack;
  logic           pkt_valid;
  logic [7:0]     pkt_pid;
  logic           pkt_tx_empty;
  pd_hash_t       pkt_hash;
  logic           sync_err;
  logic           fmt_err;
  logic [7:0]     err_cnt;
`ifdef PD_PID_FILTER_EN
  logic [7:0]     expected_pid = 8'h03;
`endif

  exp_t           exp_q[$];
  int             n_tests = 0;
  int             n_fail = 0;
  int             exp_err = 0;
  int unsigned    cyc = 0;
  int unsigned    last_acc_cyc = 0;
  bit             stall_en = 1'b0;
  bit             pkt_seen = 1'b0;
  int             ack_wait = 0;

  pd_packet_deframer dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .clear        (clear),
    .pkt_ack      (pkt_ack),
`ifdef PD_PID_FILTER_EN
    .expected_pid (expected_pid),
`endif
    .pkt_valid    (pkt_valid),
    .pkt_pid      (pkt_pid),
    .pkt_tx_empty (pkt_tx_empty),
    .pkt_hash     (pkt_hash),
    .sync_err     (sync_err),
    .fmt_err      (fmt_err),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [287:0] act, input logic [287:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] pick_pid(input logic [7:0] p);
`ifdef PD_PID_FILTER_EN
    return 8'h03;
`else
    return p;
`endif
  endfunction

  function automatic logic [15:0] garbage_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:8] == PD_SYNC_BYTE) w[15:8] = ~PD_SYNC_BYTE;
    return w;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  task automatic check_event(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d, required no event", kind);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", 288'(kind), 288'(e.kind));
    if (kind != EvPkt) begin
      if (exp_err < 255) exp_err++;
      check("err_cnt", 288'(err_cnt), 288'(exp_err));
    end else begin
      check("pkt_pid", 288'(pkt_pid), 288'(e.pid));
      check("pkt_tx_empty", 288'(pkt_tx_empty), 288'(e.te));
      check("pkt_hash", 288'(pkt_hash), 288'(e.hash));
      check("rx_ready_full", 288'(rx_ready), 288'(0));
      check("pkt_latency", 288'(cyc), 288'(last_acc_cyc));
    end
  endtask

  initial begin
    pkt_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        pkt_ack  = 1'b0;
        pkt_seen = 1'b0;
      end else begin
        if (sync_err) check_event(EvSync);
        if (fmt_err) check_event(EvFmt);
        if (pkt_valid) begin
          if (!pkt_seen) begin
            check_event(EvPkt);
            pkt_seen = 1'b1;
            ack_wait = $urandom_range(0, 4);
          end
          if (ack_wait == 0) pkt_ack = 1'b1;
          else ack_wait--;
        end else begin
          pkt_ack  = 1'b0;
          pkt_seen = 1'b0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send_word(input logic [15:0] w);
    bit acc;
    int guard = 0;
    if (stall_en) begin
      while ($urandom_range(0, 2) == 0) begin
        rx_valid = 1'b0;
        rx_data  = 16'($urandom);
        @(posedge clk); #1;
      end
    end
    rx_valid = 1'b1;
    rx_data  = w;
    forever begin
      acc = rx_ready;  // state is stable between edges
      @(posedge clk); #1;
      if (acc) break;
      guard++;
      if (guard > 2000) begin
        $display("FAIL rx_ready_timeout: got rx_ready=0 for %0d cycles, required 1", guard);
        $fatal(1, "stuck waiting for rx_ready");
      end
    end
    last_acc_cyc = cyc;
    rx_valid = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] pid, input logic te, input bit ramp);
    exp_t e;
    logic [15:0] words[HW];
    for (int i = 0; i < int'(HW); i++) begin
      words[i] = ramp ? 16'(16'h1000 + i) : 16'($urandom);
      e.hash[HW-1-i] = words[i];
    end
    e.kind = EvPkt;
    e.pid  = pid;
    e.te   = te;
    exp_q.push_back(e);
    send_word({PD_SYNC_BYTE, pid});
    send_word({15'd0, te});
    for (int i = 0; i < int'(HW); i++) send_word(words[i]);
  endtask

  task automatic send_err_word(input logic [15:0] w);
    exp_t e;
    e.kind = EvSync;
    e.pid  = '0;
    e.te   = 1'b0;
    e.hash = '0;
    exp_q.push_back(e);
    send_word(w);
  endtask

  task automatic send_bad_status(input logic [7:0] pid, input logic [15:0] st);
    exp_t e;
    e.kind = EvFmt;
    e.pid  = '0;
    e.te   = 1'b0;
    e.hash = '0;
    exp_q.push_back(e);
    send_word({PD_SYNC_BYTE, pid});
    send_word(st);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, 288'(rx_ready), 288'(1));
    check({tag, "_pkt_valid"}, 288'(pkt_valid), 288'(0));
    check({tag, "_pkt_pid"}, 288'(pkt_pid), 288'(0));
    check({tag, "_pkt_tx_empty"}, 288'(pkt_tx_empty), 288'(0));
    check({tag, "_pkt_hash"}, 288'(pkt_hash), 288'(0));
    check({tag, "_sync_err"}, 288'(sync_err), 288'(0));
    check({tag, "_fmt_err"}, 288'(fmt_err), 288'(0));
    check({tag, "_err_cnt"}, 288'(err_cnt), 288'(0));
  endtask

  initial begin
    int guard;
    rx_data  = 16'h0000;
    rx_valid = 1'b0;
    clear    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Back-to-back directed packet, no stalls.
    send_packet(pick_pid(8'h03), 1'b1, 1'b1);

    // Garbage before header.
    send_err_word(16'h1234);
    send_err_word(16'hAB54);
    send_packet(pick_pid(8'h03), 1'b0, 1'b0);

    // Bad status, then the next header word must be taken as a fresh header.
    send_bad_status(pick_pid(8'h01), 16'h0002);
    send_packet(pick_pid(8'h01), 1'b1, 1'b0);

    // Randomised mix with stalls.
    stall_en = 1'b1;
    for (int n = 0; n < 30; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5) send_packet(pick_pid(8'($urandom)), 1'($urandom), 1'b0);
      else if (r < 8) send_err_word(garbage_word());
      else send_bad_status(pick_pid(8'($urandom)), 16'($urandom_range(2, 65535)));
    end

    // clear after 10 payload words: partial packet dropped silently.
    send_word({PD_SYNC_BYTE, pick_pid(8'h77)});
    send_word(16'h0001);
    for (int i = 0; i < 10; i++) send_word(16'($urandom));
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("err_cnt_after_clear", 288'(err_cnt), 288'(exp_err));
    send_packet(pick_pid(8'h5A), 1'b0, 1'b0);

    // Saturation of the error counter.
    stall_en = 1'b0;
    for (int i = 0; i < 300; i++) send_err_word(garbage_word());
    repeat (3) @(posedge clk);
    #1;
    check("err_cnt_saturated", 288'(err_cnt), 288'(8'hFF));

    // Asynchronous reset mid-payload.
    send_word({PD_SYNC_BYTE, pick_pid(8'h22)});
    send_word(16'h0000);
    for (int i = 0; i < 5; i++) send_word(16'($urandom));
    #2;
    n_rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_err = 0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    send_packet(pick_pid(8'h44), 1'b1, 1'b0);

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    repeat (8) @(posedge clk);
    #1;
    check("queue_drained", 288'(exp_q.size()), 288'(0));
    check("err_cnt_final", 288'(err_cnt), 288'(exp_err));
    check("pkt_valid_idle", 288'(pkt_valid), 288'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
